// File: rtl/spi_master_fifo.sv
// spi_master_fifo: register-mapped SPI master with TX/RX FIFOs, burst framing and sticky overflow.
// Optional build macro SPI_AUTO_SS_EN: drive SlaveSelectors only while a burst is in flight.

module spi_master_fifo_buf #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign dout    = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

module spi_master_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_SS     = 8,
  parameter int PRE_W      = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [1:0]        Addr,
  input  logic              Wr,
  input  logic              Rd,
  input  logic [7:0]        DataWr,
  output logic [7:0]        DataRd,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCK,
  output logic [NUM_SS-1:0] SlaveSelectors
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_CONFIG = 2'd1;
  localparam logic [1:0] A_SSELEC = 2'd2;
  localparam logic [1:0] A_BUFFER = 2'd3;

  logic              en;
  logic              cpol;
  logic              cpha;
  logic [PRE_W-1:0]  pre;
  logic [NUM_SS-1:0] ssel;
  logic              rx_ovf;
  logic              tx_ovf;
  logic              busy;

  state_t            state;
  logic [7:0]        tx_sh;
  logic [7:0]        rx_sh;
  logic [PRE_W-1:0]  div_cnt;
  logic [PRE_W-1:0]  pre_l;
  logic [3:0]        edge_cnt;
  logic              cpha_l;

  logic              tx_push;
  logic              tx_pop;
  logic [7:0]        tx_dout;
  logic              tx_empty;
  logic              tx_full;
  logic              rx_push;
  logic              rx_pop;
  logic [7:0]        rx_dout;
  logic              rx_empty;
  logic              rx_full;

  assign tx_push = Wr && (Addr == A_BUFFER);
  assign rx_pop  = Rd && (Addr == A_BUFFER);
  assign tx_pop  = (state == LOAD);
  assign rx_push = (state == DONE);

  spi_master_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk(Clk), .rst_n(Rst_n), .push(tx_push), .pop(tx_pop),
    .din(DataWr), .dout(tx_dout), .empty(tx_empty), .full(tx_full)
  );

  spi_master_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk(Clk), .rst_n(Rst_n), .push(rx_push), .pop(rx_pop),
    .din(rx_sh), .dout(rx_dout), .empty(rx_empty), .full(rx_full)
  );

  // A set event in the same cycle as a clear wins, so no overflow is lost.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      en     <= 1'b0;
      cpol   <= 1'b0;
      cpha   <= 1'b0;
      pre    <= '0;
      ssel   <= '1;
      rx_ovf <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      if (Wr && Addr == A_CTRL) begin
        en <= DataWr[0];
        if (DataWr[1]) begin
          rx_ovf <= 1'b0;
          tx_ovf <= 1'b0;
        end
      end
      if (Wr && Addr == A_CONFIG) begin
        cpol <= DataWr[5];
        cpha <= DataWr[4];
        pre  <= DataWr[PRE_W-1:0];
      end
      if (Wr && Addr == A_SSELEC) ssel <= DataWr[NUM_SS-1:0];
      if (tx_push && tx_full) tx_ovf <= 1'b1;
      if (rx_push && rx_full) rx_ovf <= 1'b1;
    end
  end

  always_comb begin
    DataRd = 8'h00;
    case (Addr)
      A_CTRL:   DataRd = {busy, tx_full, tx_empty, rx_full, rx_empty, rx_ovf | tx_ovf, 1'b0, en};
      A_CONFIG: DataRd = {2'b00, cpol, cpha, 4'(pre)};
      A_SSELEC: DataRd = 8'(ssel);
      default:  DataRd = rx_empty ? 8'h00 : rx_dout;
    endcase
  end

`ifdef SPI_AUTO_SS_EN
  logic [NUM_SS-1:0] ss_q;
  assign SlaveSelectors = ss_q;
`else
  assign SlaveSelectors = ssel;
`endif

  // Edge parity against the latched CPHA decides sample versus shift on each SCK toggle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      SCK      <= 1'b0;
      MOSI     <= 1'b0;
      tx_sh    <= 8'h00;
      rx_sh    <= 8'h00;
      div_cnt  <= '0;
      pre_l    <= '0;
      edge_cnt <= 4'd0;
      cpha_l   <= 1'b0;
`ifdef SPI_AUTO_SS_EN
      ss_q     <= '1;
`endif
    end else begin
      case (state)
        IDLE: begin
          SCK <= cpol;
          if (en && !tx_empty) begin
            state <= LOAD;
            busy  <= 1'b1;
`ifdef SPI_AUTO_SS_EN
            ss_q  <= ssel;
`endif
          end
        end
        LOAD: begin
          cpha_l   <= cpha;
          pre_l    <= pre;
          SCK      <= cpol;
          div_cnt  <= '0;
          edge_cnt <= 4'd0;
          if (!cpha) begin
            MOSI  <= tx_dout[7];
            tx_sh <= {tx_dout[6:0], 1'b0};
          end else begin
            tx_sh <= tx_dout;
          end
          state <= SHIFT;
        end
        SHIFT: begin
          if (div_cnt == pre_l) begin
            div_cnt  <= '0;
            SCK      <= ~SCK;
            edge_cnt <= edge_cnt + 4'd1;
            if (edge_cnt[0] == cpha_l) begin
              rx_sh <= {rx_sh[6:0], MISO};
            end else begin
              MOSI  <= tx_sh[7];
              tx_sh <= {tx_sh[6:0], 1'b0};
            end
            if (edge_cnt == 4'd15) state <= DONE;
          end else begin
            div_cnt <= div_cnt + PRE_W'(1);
          end
        end
        default: begin
          if (en && !tx_empty) begin
            state <= LOAD;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
`ifdef SPI_AUTO_SS_EN
            ss_q  <= '1;
`endif
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_fifo.sv
// tb_spi_master_fifo: scoreboard bench for spi_master_fifo covering loopback, all modes, bursts,
// FIFO overflow and mid-frame reset; SlaveSelectors expectations follow SPI_AUTO_SS_EN.

module tb_spi_master_fifo;
  localparam int NUM_SS = 8;

`ifdef SPI_AUTO_SS_EN
  localparam logic [7:0] SS_IDLE_EXP = 8'hFF;
`else
  localparam logic [7:0] SS_IDLE_EXP = 8'hFE;
`endif

  logic              Clk = 1'b0;
  logic              Rst_n = 1'b0;
  logic [1:0]        Addr = 2'd0;
  logic              Wr = 1'b0;
  logic              Rd = 1'b0;
  logic [7:0]        DataWr = 8'h00;
  logic [7:0]        DataRd;
  logic              MISO;
  logic              MOSI;
  logic              SCK;
  logic [NUM_SS-1:0] SlaveSelectors;

  logic              loop_mode = 1'b1;
  logic              slave_cpha = 1'b0;
  logic [7:0]        slave_byte = 8'h00;
  logic              resync = 1'b0;
  logic              resync_seen = 1'b0;
  logic              slave_miso = 1'b0;
  logic [7:0]        slave_rx = 8'h00;
  int                slave_edges = 0;
  int                slave_samples = 0;

  int                total = 0;
  int                bad = 0;
  logic [7:0]        sb [$];

  spi_master_fifo #(.FIFO_DEPTH(4), .NUM_SS(NUM_SS), .PRE_W(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Addr(Addr), .Wr(Wr), .Rd(Rd),
    .DataWr(DataWr), .DataRd(DataRd), .MISO(MISO), .MOSI(MOSI),
    .SCK(SCK), .SlaveSelectors(SlaveSelectors)
  );

  always #5 Clk = ~Clk;

  assign MISO = loop_mode ? MOSI : slave_miso;

  // Slave model: presents its byte MSB first and captures MOSI on the sample edges.
  always @(SCK or resync) begin
    if (resync != resync_seen) begin
      resync_seen   = resync;
      slave_edges   = 0;
      slave_samples = 0;
      slave_rx      = 8'h00;
    end else begin
      slave_edges = slave_edges + 1;
      if ((slave_edges % 2 == 1) == (slave_cpha == 1'b0)) begin
        slave_rx      = {slave_rx[6:0], MOSI};
        slave_samples = slave_samples + 1;
      end
      if (slave_edges == 16) slave_edges = 0;
    end
    slave_miso = (slave_samples < 8) ? slave_byte[3'(7 - slave_samples)] : 1'b0;
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge Clk);
    Addr = a; DataWr = d; Wr = 1'b1;
    @(negedge Clk);
    Wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge Clk);
    Addr = a;
    #1 d = DataRd;
  endtask

  task automatic push_tx(input logic [7:0] d, input logic [7:0] exp, input bit expect_rx);
    bus_write(2'd3, d);
    if (expect_rx) sb.push_back(exp);
  endtask

  task automatic pop_and_check(input string tag);
    logic [7:0] d;
    logic [7:0] e;
    @(negedge Clk);
    Addr = 2'd3; Rd = 1'b1;
    #1 d = DataRd;
    @(negedge Clk);
    Rd = 1'b0;
    check_output({tag, "_sb_avail"}, 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_output(tag, d, e);
    end
  endtask

  // Called right after the write that creates the start condition.
  task automatic measure_busy(output int lat, output int cycles,
                              output logic [7:0] ctrl_fall, output logic [7:0] ss_busy);
    lat = 0; cycles = 0;
    Addr = 2'd0;
    #1;
    while (!DataRd[7] && lat < 200) begin
      @(negedge Clk); #1; lat++;
    end
    check_output("busy_seen", DataRd[7], 1);
    ss_busy = SlaveSelectors;
    while (DataRd[7] && cycles < 2000) begin
      cycles++;
      @(negedge Clk); #1;
    end
    check_output("busy_fall", DataRd[7], 0);
    ctrl_fall = DataRd;
  endtask

  task automatic apply_stimulus(input string tag, input int exp_cycles);
    int lat, cycles;
    logic [7:0] cf, ssb;
    measure_busy(lat, cycles, cf, ssb);
    check_output({tag, "_latency"}, 32'(lat), 1);
    check_output({tag, "_cycles"}, 32'(cycles), 32'(exp_cycles));
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] cf;
    logic [7:0] ssb;
    logic [7:0] mode_bytes [4];
    int lat, cycles;
    mode_bytes[0] = 8'hAA; mode_bytes[1] = 8'h72;
    mode_bytes[2] = 8'hC3; mode_bytes[3] = 8'h5D;

    // Reset values
    repeat (3) @(negedge Clk);
    #1;
    check_output("rst_sck", SCK, 0);
    check_output("rst_mosi", MOSI, 0);
    check_output("rst_ss", 32'(SlaveSelectors), 32'hFF);
    check_output("rst_ctrl", DataRd, 8'h28);
    Rst_n = 1'b1;
    bus_read(2'd1, d); check_output("rst_config", d, 8'h00);
    bus_read(2'd2, d); check_output("rst_sselec", d, 8'hFF);

    // Single loopback frame, mode 0, PRE=2
    bus_write(2'd1, 8'h02);
    bus_write(2'd2, 8'hFE);
    bus_write(2'd0, 8'h01);
    #1 check_output("ss_idle", 32'(SlaveSelectors), 32'(SS_IDLE_EXP));
    push_tx(8'hBB, 8'hBB, 1'b1);
    measure_busy(lat, cycles, cf, ssb);
    check_output("t1_latency", 32'(lat), 1);
    check_output("t1_cycles", 32'(cycles), 50);
    check_output("t1_rx_nonempty_at_fall", cf[3], 0);
    check_output("ss_busy", 32'(ssb), 32'hFE);
    @(negedge Clk); #1;
    check_output("ss_after", 32'(SlaveSelectors), 32'(SS_IDLE_EXP));
    pop_and_check("t1_rx");
    bus_write(2'd0, 8'h00);
    bus_read(2'd0, d); check_output("t1_ctrl", d, 8'h28);

    // All four modes against the slave model, PRE=1
    loop_mode = 1'b0;
    bus_write(2'd0, 8'h01);
    for (int m = 0; m < 4; m++) begin
      logic [7:0] txb;
      txb = 8'h5A ^ 8'(m * 8'h13);
      bus_write(2'd1, {2'b00, m[1], m[0], 4'd1});
      slave_cpha = m[0];
      slave_byte = mode_bytes[m];
      repeat (3) @(negedge Clk);
      resync = ~resync;
      push_tx(txb, mode_bytes[m], 1'b1);
      apply_stimulus($sformatf("mode%0d", m), 34);
      repeat (2) @(negedge Clk);
      #1 check_output($sformatf("mode%0d_sck_idle", m), SCK, m[1]);
      check_output($sformatf("mode%0d_slave_rx", m), slave_rx, txb);
      pop_and_check($sformatf("mode%0d_rx", m));
    end

    // Burst of four loopback frames, PRE=0
    loop_mode = 1'b1;
    bus_write(2'd0, 8'h00);
    bus_write(2'd1, 8'h00);
    push_tx(8'h11, 8'h11, 1'b1);
    push_tx(8'h22, 8'h22, 1'b1);
    push_tx(8'h33, 8'h33, 1'b1);
    push_tx(8'h44, 8'h44, 1'b1);
    bus_write(2'd0, 8'h01);
    apply_stimulus("burst", 72);
    for (int i = 0; i < 4; i++) pop_and_check($sformatf("burst_rx%0d", i));

    // TX overflow, then RX overflow on a fifth frame
    bus_write(2'd0, 8'h00);
    push_tx(8'hA1, 8'hA1, 1'b1);
    push_tx(8'hA2, 8'hA2, 1'b1);
    push_tx(8'hA3, 8'hA3, 1'b1);
    push_tx(8'hA4, 8'hA4, 1'b1);
    push_tx(8'hA5, 8'hA5, 1'b0);
    bus_read(2'd0, d); check_output("txovf_ctrl", d, 8'h4C);
    bus_write(2'd0, 8'h02);
    bus_read(2'd0, d); check_output("txovf_clear", d, 8'h48);
    bus_write(2'd0, 8'h01);
    apply_stimulus("ovf_burst", 72);
    push_tx(8'h99, 8'h99, 1'b0);
    apply_stimulus("ovf_fifth", 18);
    bus_read(2'd0, d); check_output("rxovf_ctrl", d, 8'h35);
    bus_write(2'd0, 8'h03);
    bus_read(2'd0, d); check_output("rxovf_clear", d, 8'h31);
    for (int i = 0; i < 4; i++) pop_and_check($sformatf("ovf_rx%0d", i));
    bus_read(2'd3, d); check_output("rx_empty_read", d, 8'h00);
    bus_read(2'd0, d); check_output("post_ovf_ctrl", d, 8'h29);

    // Reset pulse in the middle of a mode-2 frame
    bus_write(2'd1, 8'h22);
    push_tx(8'hFF, 8'hFF, 1'b0);
    Addr = 2'd0;
    lat = 0;
    #1;
    while (!DataRd[7] && lat < 200) begin
      @(negedge Clk); #1; lat++;
    end
    check_output("rst_busy_seen", DataRd[7], 1);
    repeat (19) @(negedge Clk);
    #1 Rst_n = 1'b0;
    #1;
    check_output("midrst_sck", SCK, 0);
    check_output("midrst_mosi", MOSI, 0);
    check_output("midrst_ss", 32'(SlaveSelectors), 32'hFF);
    check_output("midrst_ctrl", DataRd, 8'h28);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (60) @(negedge Clk);
    bus_read(2'd0, d); check_output("midrst_ctrl_later", d, 8'h28);
    bus_read(2'd1, d); check_output("midrst_config", d, 8'h00);
    bus_read(2'd3, d); check_output("midrst_rx", d, 8'h00);
    check_output("sb_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_master_fifo.md
# spi_master_fifo

Parametrised successor to the single-buffer SPI master. It is a register-mapped SPI master with TX/RX FIFOs of configurable depth, a configurable slave-select count and prescaler width, back-to-back frame bursting, and sticky overflow flags. It sits on the same 2-bit-address / 8-bit register bus as the existing master. It drives SCK/MOSI/SlaveSelectors toward external slaves and samples MISO.

## Interface
- FIFO_DEPTH, 4, entries per TX and RX FIFO; power of two, ≥2
- NUM_SS, 8, slave-select lines; 1..8
- PRE_W, 4, prescaler field width; 1..4
- Clk  in  1  system clock; single clock domain
- Rst_n  in  1  asynchronous, active-low reset
- Addr  in  2  register address: 0 CTRL, 1 CONFIG, 2 SSELEC, 3 BUFFER
- Wr  in  1  write strobe, sampled on rising Clk
- Rd  in  1  read strobe; pops the RX FIFO when Addr=3
- DataWr  in  8  write data
- DataRd  out  8  read data, combinational mux on Addr
- MISO  in  1  serial data from slave
- MOSI  out  1  serial data to slave
- SCK  out  1  serial clock
- SlaveSelectors  out  NUM_SS  active-low selects

## Operation
- CTRL (0)
  - [0] En, R/W.
  - [1] Write 1 clears both sticky errors; reads 0.
  - [2] rx_ovf, sticky.
  - [3] rx_empty.
  - [4] rx_full.
  - [5] tx_empty.
  - [6] tx_full.
  - [7] Busy.
  - Bits [7:2] are read-only.
- CONFIG (1): [5] CPOL, [4] CPHA, [PRE_W-1:0] PRE. Other bits read 0. Mode and PRE are sampled at LOAD of each frame.
- SSELEC (2): select pattern, low bits NUM_SS used.
- BUFFER (3)
  - Write pushes to the TX FIFO. If the FIFO is full, the write is dropped and tx_ovf (CTRL[6] read as tx_full; tx_ovf is internal and merged into rx_ovf bit) is set.
  - Read returns the RX head, or 0x00 if empty.
  - Rd with Addr=3 pops the head; Rd on an empty FIFO has no effect.
- Frames are 8 bits, MSB first.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE → LOAD when En=1 and TX is not empty.
- LOAD (1 clk)
  - Pop TX into the shift register; bit counter = 0; Busy=1.
  - If CPHA=0, MOSI = bit 7.
- SHIFT: 16 half-periods of PRE+1 clocks each. SCK toggles at the end of each half-period.
  - CPHA=0: odd edges sample MISO; even edges shift MOSI.
  - CPHA=1: odd edges shift MOSI; even edges sample MISO.
- DONE (1 clk)
  - Push the received byte to RX. If RX is full, drop the byte and set rx_ovf.
  - If En=1 and TX is not empty, go to LOAD (burst); otherwise go to IDLE with Busy=0.
- SCK idles at CPOL whenever the FSM is in IDLE.
- Clearing En mid-frame completes the current frame, then the FSM goes to IDLE.
- Simultaneous FIFO push and pop in one clock are both performed; the count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is FIFO_DEPTH+1 states wide.

## Timing
- Frame length is 2 + 16·(PRE+1) clocks. With PRE=2 this is 50 clocks.
- A burst of N frames takes N·(2 + 16·(PRE+1)) clocks, with no idle gap between frames.
- Busy rises one clock after the BUFFER write (or En set) that makes the start condition true.
- Busy falls on the clock after DONE when no further frame follows.
- rx_empty deasserts in the same cycle Busy falls for a single frame.
- Register writes take effect on the next Clk rising edge. DataRd is valid combinationally.
- Reset values:
  - SCK=0, MOSI=0, SlaveSelectors=all ones.
  - CTRL=0x28 (tx_empty, rx_empty).
  - CONFIG=0, SSELEC=all ones.
  - FIFOs empty, FSM in IDLE.
- Reset asserted mid-frame aborts the frame immediately and asynchronously. No RX push occurs.

## Configuration
- SPI_AUTO_SS_EN defined:
  - SlaveSelectors = SSELEC only from LOAD of the first frame through DONE of the last frame of a burst.
  - Otherwise SlaveSelectors are all ones.
  - Selects stay asserted across back-to-back frames.
- SPI_AUTO_SS_EN undefined: SlaveSelectors = SSELEC at all times.

## Test plan
- MOSI looped to MISO, mode 0, PRE=2, write 0xBB:
  - Busy is high for 50 clocks.
  - BUFFER read returns 0xBB.
  - CTRL returns 0x28.
- Slave model answering 0xAA, 0x72, 0xC3, 0x5D in modes 0–3:
  - Each mode returns its byte.
  - SCK idles at CPOL between frames.
- Loopback, 4 writes 0x11, 0x22, 0x33, 0x44 with En=1, PRE=0:
  - Burst lasts 4·18 = 72 clocks.
  - RX pops 0x11, 0x22, 0x33, 0x44 in order.
- FIFO_DEPTH=4, 5 frames sent without reads:
  - rx_full=1, rx_ovf=1.
  - RX holds the first 4 bytes.
  - Writing CTRL[1]=1 clears rx_ovf.
- Rst_n pulsed low at clock 20 of a frame:
  - All outputs go to reset values immediately.
  - RX stays empty.
- SPI_AUTO_SS_EN build, SSELEC=0xFE:
  - SlaveSelectors reads 0xFF idle.
  - SlaveSelectors reads 0xFE exactly during the burst.
  - Without the macro, SlaveSelectors is constantly 0xFE.
